// File: rtl/datapath_seq_ctrl.sv
// Multi-cycle FETCH/EXEC/MEM/WB control sequencer for the 64-bit LEGv8 datapath.
// Optional build macro PERF_CNT_EN adds retired/stall performance counters.
module datapath_seq_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ack,
    input  logic [3:0]  flags,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        ChooseImm,
    output logic        xferByte,
    output logic        ChooseMovk,
    output logic [2:0]  ALUOp,
    output logic        flag_we,
    output logic        pc_en,
    output logic        br_taken,
    output logic        uncond_br,
    output logic        illegal,
    output logic        mem_err,
    output logic        busy
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] MEM   = 2'd2;
    localparam logic [1:0] WB    = 2'd3;

    localparam logic [3:0] K_ILL  = 4'd0;
    localparam logic [3:0] K_ADDS = 4'd1;
    localparam logic [3:0] K_SUBS = 4'd2;
    localparam logic [3:0] K_AND  = 4'd3;
    localparam logic [3:0] K_EOR  = 4'd4;
    localparam logic [3:0] K_ADDI = 4'd5;
    localparam logic [3:0] K_MOVK = 4'd6;
    localparam logic [3:0] K_LD   = 4'd7;
    localparam logic [3:0] K_ST   = 4'd8;
    localparam logic [3:0] K_B    = 4'd9;
    localparam logic [3:0] K_CBZ  = 4'd10;
    localparam logic [3:0] K_BC   = 4'd11;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    typedef struct packed {
        logic       reg2loc, alusrc, memtoreg, regwrite, memwrite, memread;
        logic       chooseimm, xferbyte, choosemovk;
        logic [2:0] aluop;
        logic       flagwe, pcen, brtaken, uncondbr, illegal, busy, ack;
    } ctl_t;

    // Only the opcode field and the B.cond condition are ever decoded.
    logic [15:0] instr_q, instr_d;
    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [3:0]  kind;
    logic        is_byte, cond_ok;
    ctl_t        ctl, ctl_o;
    logic        unused_in;

    assign unused_in = ^{flags[0], instr[20:5]};

    wire [10:0] op11 = instr_q[15:5];

    always_comb begin
        kind    = K_ILL;
        is_byte = 1'b0;
        if (op11 == 11'b10101011000)               kind = K_ADDS;
        else if (op11 == 11'b11101011000)          kind = K_SUBS;
        else if (op11 == 11'b10001010000)          kind = K_AND;
        else if (op11 == 11'b11001010000)          kind = K_EOR;
        else if (op11 == 11'b11111000010)          kind = K_LD;
        else if (op11 == 11'b11111000000)          kind = K_ST;
        else if (op11 == 11'b00111000010) begin    kind = K_LD; is_byte = 1'b1; end
        else if (op11 == 11'b00111000000) begin    kind = K_ST; is_byte = 1'b1; end
        else if (op11[10:1] == 10'b1001000100)     kind = K_ADDI;
        else if (op11[10:2] == 9'b111100101)       kind = K_MOVK;
        else if (op11[10:3] == 8'b01010100)        kind = K_BC;
        else if (op11[10:3] == 8'b10110100)        kind = K_CBZ;
        else if (op11[10:5] == 6'b000101)          kind = K_B;
    end

    // Condition codes against {N,Z,V,C}; unlisted encodings are never taken.
    always_comb begin
        case (instr_q[4:0])
            5'h00:   cond_ok = flags[2];
            5'h01:   cond_ok = !flags[2];
            5'h0A:   cond_ok = (flags[3] == flags[1]);
            5'h0B:   cond_ok = (flags[3] != flags[1]);
            5'h0C:   cond_ok = !flags[2] && (flags[3] == flags[1]);
            5'h0D:   cond_ok = flags[2] || (flags[3] != flags[1]);
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        ctl       = '0;
        state_d   = state_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            FETCH: begin
                ctl.ack = 1'b1;
                if (instr_valid) begin
                    instr_d = {instr[31:21], instr[4:0]};
                    state_d = EXEC;
                end
            end
            EXEC: begin
                ctl.busy = 1'b1;
                cnt_d    = '0;
                state_d  = FETCH;
                case (kind)
                    K_ADDS, K_SUBS, K_AND, K_EOR: begin
                        ctl.reg2loc  = 1'b1;
                        ctl.regwrite = 1'b1;
                        ctl.pcen     = 1'b1;
                        ctl.flagwe   = (kind == K_ADDS) || (kind == K_SUBS);
                        ctl.aluop    = (kind == K_ADDS) ? ALU_ADD :
                                       (kind == K_SUBS) ? ALU_SUB :
                                       (kind == K_AND)  ? ALU_AND : ALU_XOR;
                    end
                    K_ADDI: begin
                        ctl.chooseimm = 1'b1;
                        ctl.aluop     = ALU_ADD;
                        ctl.regwrite  = 1'b1;
                        ctl.pcen      = 1'b1;
                    end
                    K_MOVK: begin
                        ctl.choosemovk = 1'b1;
                        ctl.aluop      = ALU_PASS;
                        ctl.regwrite   = 1'b1;
                        ctl.pcen       = 1'b1;
                    end
                    K_LD, K_ST: begin
                        ctl.alusrc   = 1'b1;
                        ctl.aluop    = ALU_ADD;
                        ctl.memread  = (kind == K_LD);
                        ctl.xferbyte = is_byte;
                        state_d      = MEM;
                    end
                    K_B: begin
                        ctl.pcen     = 1'b1;
                        ctl.brtaken  = 1'b1;
                        ctl.uncondbr = 1'b1;
                    end
                    K_CBZ: begin
                        ctl.pcen    = 1'b1;
                        ctl.brtaken = alu_zero;
                    end
                    K_BC: begin
                        ctl.pcen    = 1'b1;
                        ctl.brtaken = cond_ok;
                    end
                    default: begin
                        ctl.illegal = 1'b1;
                        ctl.pcen    = 1'b1;
                    end
                endcase
            end
            MEM: begin
                ctl.busy     = 1'b1;
                ctl.alusrc   = 1'b1;
                ctl.aluop    = ALU_ADD;
                ctl.xferbyte = is_byte;
                ctl.memread  = (kind == K_LD);
                ctl.memwrite = (kind != K_LD);
                // A ready arriving on the final allowed cycle still wins over the timeout.
                if (mem_ready) begin
                    if (kind == K_LD) begin
                        state_d = WB;
                    end else begin
                        ctl.pcen = 1'b1;
                        state_d  = FETCH;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    mem_err_d = 1'b1;
                    ctl.pcen  = 1'b1;
                    state_d   = FETCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                ctl.busy     = 1'b1;
                ctl.memtoreg = 1'b1;
                ctl.regwrite = 1'b1;
                ctl.alusrc   = 1'b1;
                ctl.aluop    = ALU_ADD;
                ctl.xferbyte = is_byte;
                ctl.pcen     = 1'b1;
                state_d      = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= FETCH;
            instr_q   <= '0;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Outputs are forced quiet for as long as reset is held low.
    assign ctl_o   = reset ? ctl : '0;
    assign mem_err = reset & mem_err_q;
    assign {Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, ChooseImm, xferByte,
            ChooseMovk, ALUOp, flag_we, pc_en, br_taken, uncond_br, illegal, busy,
            instr_ack} = ctl_o;

`ifdef PERF_CNT_EN
    logic [31:0] retired_q, stall_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (ctl.pcen) retired_q <= retired_q + 32'd1;
            if ((state_q == MEM && !mem_ready) || (state_q == FETCH && !instr_valid))
                stall_q <= stall_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Directed, table-driven bench for datapath_seq_ctrl (default build, MEM_TIMEOUT=16).
module tb_datapath_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic [3:0]  flags;
    logic        alu_zero;
    logic        mem_ready;
    logic        Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, MemRead;
    logic        ChooseImm, xferByte, ChooseMovk;
    logic [2:0]  ALUOp;
    logic        flag_we, pc_en, br_taken, uncond_br, illegal, mem_err, busy;

    int checks = 0;
    int errors = 0;

    datapath_seq_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ack(instr_ack), .flags(flags), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .MemRead(MemRead), .ChooseImm(ChooseImm), .xferByte(xferByte),
        .ChooseMovk(ChooseMovk), .ALUOp(ALUOp), .flag_we(flag_we), .pc_en(pc_en),
        .br_taken(br_taken), .uncond_br(uncond_br), .illegal(illegal), .mem_err(mem_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Observed control vector; bit masks below name each field.
    logic [18:0] obs;
    assign obs = {Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, ChooseImm,
                  xferByte, ChooseMovk, ALUOp, flag_we, pc_en, br_taken, uncond_br,
                  illegal, busy, instr_ack};

    localparam logic [18:0] ACK  = 19'd1 << 0;
    localparam logic [18:0] BSY  = 19'd1 << 1;
    localparam logic [18:0] ILL  = 19'd1 << 2;
    localparam logic [18:0] UNC  = 19'd1 << 3;
    localparam logic [18:0] BRT  = 19'd1 << 4;
    localparam logic [18:0] PC   = 19'd1 << 5;
    localparam logic [18:0] FWE  = 19'd1 << 6;
    localparam logic [18:0] ADD  = 19'd2 << 7;
    localparam logic [18:0] SUB  = 19'd3 << 7;
    localparam logic [18:0] ANDO = 19'd4 << 7;
    localparam logic [18:0] XORO = 19'd6 << 7;
    localparam logic [18:0] MVK  = 19'd1 << 10;
    localparam logic [18:0] XB   = 19'd1 << 11;
    localparam logic [18:0] CIM  = 19'd1 << 12;
    localparam logic [18:0] MRD  = 19'd1 << 13;
    localparam logic [18:0] MWR  = 19'd1 << 14;
    localparam logic [18:0] RW   = 19'd1 << 15;
    localparam logic [18:0] M2R  = 19'd1 << 16;
    localparam logic [18:0] ASR  = 19'd1 << 17;
    localparam logic [18:0] R2L  = 19'd1 << 18;

    typedef struct {
        string       name;
        logic [31:0] word;
        logic [3:0]  fl;
        logic        zero;
        logic [18:0] expv;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string n, input logic [31:0] w, input logic [3:0] f,
                          input logic z, input logic [18:0] e);
        vec_t v;
        v.name = n; v.word = w; v.fl = f; v.zero = z; v.expv = e;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string n, input logic [18:0] e);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("[TB] FAIL %s: controls got %05h want %05h", n, obs, e);
        end
    endtask

    task automatic checkErr(input string n, input logic e);
        checks++;
        if (mem_err !== e) begin
            errors++;
            $display("[TB] FAIL %s: mem_err got %b want %b", n, mem_err, e);
        end
    endtask

    // Presents an instruction in FETCH and leaves time at the EXEC sample point.
    task automatic applyStimulus(input logic [31:0] w, input logic [3:0] f, input logic z);
        instr = w; flags = f; alu_zero = z; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        #1;
    endtask

    task automatic nextCycle(input logic rdy);
        @(posedge clk); #1;
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        reset = 1'b0; instr = 32'hAB030041; instr_valid = 1'b1;
        flags = 4'b0000; alu_zero = 1'b0; mem_ready = 1'b0;

        repeat (2) begin
            @(posedge clk); #2;
            checkOutput("reset_hold", '0);
            checkErr("reset_hold_err", 1'b0);
        end
        reset = 1'b1; instr_valid = 1'b0;
        #1;
        checkOutput("first_fetch", ACK);

        addVec("adds",   32'hAB030041, 4'b0000, 1'b0, R2L | RW | ADD | FWE | PC | BSY);
        addVec("subs",   32'hEB030041, 4'b0000, 1'b0, R2L | RW | SUB | FWE | PC | BSY);
        addVec("and",    32'h8A030041, 4'b0000, 1'b0, R2L | RW | ANDO | PC | BSY);
        addVec("eor",    32'hCA030041, 4'b0000, 1'b0, R2L | RW | XORO | PC | BSY);
        addVec("addi",   32'h91000441, 4'b0000, 1'b0, CIM | ADD | RW | PC | BSY);
        addVec("movk",   32'hF2800041, 4'b0000, 1'b0, MVK | RW | PC | BSY);
        addVec("b",      32'h14000010, 4'b0000, 1'b0, PC | BRT | UNC | BSY);
        addVec("cbz_t",  32'hB4000041, 4'b0000, 1'b1, PC | BRT | BSY);
        addVec("cbz_nt", 32'hB4000041, 4'b0000, 1'b0, PC | BSY);
        addVec("blt_t",  32'h5400004B, 4'b1000, 1'b0, PC | BRT | BSY);
        addVec("blt_nt", 32'h5400004B, 4'b1010, 1'b0, PC | BSY);
        addVec("beq_t",  32'h54000040, 4'b0100, 1'b0, PC | BRT | BSY);
        addVec("bne_nt", 32'h54000041, 4'b0100, 1'b0, PC | BSY);
        addVec("bge_t",  32'h5400004A, 4'b0000, 1'b0, PC | BRT | BSY);
        addVec("bgt_t",  32'h5400004C, 4'b1010, 1'b0, PC | BRT | BSY);
        addVec("ble_nt", 32'h5400004D, 4'b0000, 1'b0, PC | BSY);
        addVec("bal_nt", 32'h5400004E, 4'b0100, 1'b0, PC | BSY);
        addVec("illeg",  32'h00000000, 4'b0000, 1'b0, ILL | PC | BSY);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].word, vecs[i].fl, vecs[i].zero);
            checkOutput({vecs[i].name, "_exec"}, vecs[i].expv);
            nextCycle(1'b0);
            checkOutput({vecs[i].name, "_back"}, ACK);
        end

        // Byte load: three wait cycles then ready, then write-back.
        applyStimulus(32'h38400000, 4'b0000, 1'b0);
        checkOutput("ldurb_exec", ASR | ADD | MRD | XB | BSY);
        for (int i = 0; i < 4; i++) begin
            nextCycle(i == 3);
            checkOutput($sformatf("ldurb_mem%0d", i), ASR | ADD | MRD | XB | BSY);
        end
        nextCycle(1'b0);
        checkOutput("ldurb_wb", M2R | RW | ASR | ADD | XB | PC | BSY);
        nextCycle(1'b0);
        checkOutput("ldurb_done", ACK);

        // Ready on the last allowed MEM cycle counts as success.
        applyStimulus(32'hF8400000, 4'b0000, 1'b0);
        checkOutput("ldur_exec", ASR | ADD | MRD | BSY);
        for (int i = 0; i < 16; i++) begin
            nextCycle(i == 15);
            checkOutput($sformatf("ldur_mem%0d", i), ASR | ADD | MRD | BSY);
        end
        nextCycle(1'b0);
        checkOutput("ldur_edge_wb", M2R | RW | ASR | ADD | PC | BSY);
        checkErr("ldur_edge_err", 1'b0);
        nextCycle(1'b0);
        checkOutput("ldur_edge_done", ACK);

        applyStimulus(32'h38000000, 4'b0000, 1'b0);
        checkOutput("sturb_exec", ASR | ADD | XB | BSY);
        nextCycle(1'b1);
        checkOutput("sturb_mem", ASR | ADD | MWR | XB | PC | BSY);
        nextCycle(1'b0);
        checkOutput("sturb_done", ACK);

        // Store that never sees ready: times out and latches mem_err.
        applyStimulus(32'hF8000000, 4'b0000, 1'b0);
        checkOutput("stur_exec", ASR | ADD | BSY);
        for (int i = 0; i < 16; i++) begin
            nextCycle(1'b0);
            checkOutput($sformatf("stur_mem%0d", i),
                        ASR | ADD | MWR | BSY | ((i == 15) ? PC : 19'd0));
        end
        checkErr("stur_err_pre", 1'b0);
        nextCycle(1'b0);
        checkOutput("stur_to_fetch", ACK);
        checkErr("stur_err_set", 1'b1);
        applyStimulus(32'h91000441, 4'b0000, 1'b0);
        checkOutput("addi_after_err", CIM | ADD | RW | PC | BSY);
        checkErr("err_sticky", 1'b1);
        nextCycle(1'b0);
        checkOutput("addi_after_back", ACK);

        // Reset pulled low while a load sits in MEM.
        applyStimulus(32'hF8400000, 4'b0000, 1'b0);
        checkOutput("rst_ld_exec", ASR | ADD | MRD | BSY);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_quiet", '0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_fetch", ACK);
        checkErr("rst_mid_err_clr", 1'b0);
        nextCycle(1'b1);
        checkOutput("rst_mid_stay", ACK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
